lcd_cmd_scheduler: RTL and testbench
====================================

// Module: lcd_cmd_scheduler
// PURPOSE
//  Owns the HD44780-style 4-bit LCD bus (data/rs/rw/en) and schedules all traffic onto it.
//  After reset it runs the power-on init sequence on its own, then arbitrates byte requests
//  from two clients: A = cursor/control, fixed high priority; B = character writer.
//  Each accepted byte goes out as two nibbles with exact EN timing and command execution waits.
// PARAMETERS (cycle counts at 100 MHz)
//  T_PWRUP   1500000  power-up wait before the first init nibble (15 ms)
//  T_INIT1    410000  wait after the first 0x3 init nibble (4.1 ms)
//  T_INIT2     10000  wait after the second 0x3 init nibble (100 us)
//  T_SETUP         4  data/rs valid before EN rises
//  T_EN           50  EN high width (500 ns)
//  T_GAP         100  EN low between the hi and lo nibble (1 us)
//  T_CMD        4000  execution wait, normal command/data (40 us)
//  T_CLEAR    164000  execution wait, clear/home (1.64 ms)
// PORTS
//  clk         in   1  system clock
//  nrst        in   1  asynchronous active-low reset
//  a_valid     in   1  client A request valid
//  a_rs        in   1  client A register select (0 = cmd, 1 = data)
//  a_byte      in   8  client A byte
//  a_ready     out  1  client A accept
//  b_valid     in   1  client B request valid
//  b_rs        in   1  client B register select
//  b_byte      in   8  client B byte
//  b_ready     out  1  client B accept
//  data        out  4  LCD DB7..DB4
//  rs          out  1  LCD register select
//  rw          out  1  LCD read/write; tied 0 (write only)
//  en          out  1  LCD enable strobe
//  init_done   out  1  high from end of init until next reset
//  busy        out  1  high whenever the state is not IDLE
// BEHAVIOUR
//  Reset (async): data=0, rs=0, rw=0, en=0, a_ready=0, b_ready=0, init_done=0, busy=1; state=PWRUP.
//  One 32-bit down-counter; load N-1 on state entry; advance on the cycle the counter reads 0.
//  Each timed state therefore lasts exactly N cycles.
//  Init, in order:
//   - PWRUP T_PWRUP
//   - nibble 0x3, wait T_INIT1; nibble 0x3, wait T_INIT2
//   - nibble 0x3, wait T_CMD; nibble 0x2, wait T_CMD
//   - bytes 0x28, 0x0C, 0x01, 0x06 with rs=0, each via the byte path below
//   - then init_done=1 and go to IDLE
//  Nibble path: SETUP(T_SETUP, en=0, data/rs driven) -> EN_HI(T_EN, en=1) -> EN_LO(en=0).
//  Byte path: hi nibble SETUP/EN_HI -> GAP(T_GAP) -> lo nibble SETUP/EN_HI -> EXEC.
//  EXEC wait = T_CLEAR if rs=0 and byte is 0x01..0x03; otherwise T_CMD.
//  EXEC returns to the next init step or to IDLE.
//  Handshake, both outputs combinational from registered state:
//   - a_ready = IDLE & init_done
//   - b_ready = IDLE & init_done & ~a_valid
//  Transfer occurs when valid & ready. rs and byte are latched that cycle.
//  The hi nibble appears on data the next cycle; EN first rises T_SETUP cycles after that.
//  Simultaneous a_valid and b_valid: A always wins. B waits with no starvation guard.
//  Requests are ignored while init_done=0 (ready stays 0). Clients hold valid until accepted.
//  data/rs hold their value through EN falling, and are only updated when the next SETUP starts.
//  Reset mid-transfer: en drops immediately and the full init sequence restarts.
//  Back-to-back requests: minimum one IDLE cycle between bytes.
// STRUCTURE
//  lcd_pkg holds:
//   - state enum
//   - timing defaults
//   - init command constants: CMD_FUNC_4BIT=0x28, CMD_DISP_ON=0x0C, CMD_CLEAR=0x01, CMD_ENTRY=0x06
//  Sub-module lcd_init_rom: combinational step index (3 bits) -> {is_nibble, rs, value[7:0], wait}.
//  The scheduler FSM, counter and arbiter stay in this module.
// TESTING (scale timings in sim: T_PWRUP=200, T_INIT1=50, T_INIT2=20, T_CMD=10, T_CLEAR=30)
//  1. Release reset -> EN pulses carry 3,3,3,2,2,8,0,C,0,1,0,6; init_done rises after the last EXEC.
//  2. b: rs=1, 0x41 -> data 0x4 then 0x1, rs=1 on both pulses, each EN pulse exactly T_EN cycles wide.
//  3. a and b valid in the same IDLE cycle -> a_ready=1, b_ready=0; A's byte goes out first.
//     B is accepted at the next IDLE.
//  4. a: rs=0, 0x01 -> busy stays high for T_CLEAR cycles after the lo EN falls, then IDLE.
//  5. b_valid held during init -> b_ready=0 until init_done=1; accepted on the first IDLE cycle.
//  6. Assert nrst while en=1 mid-byte -> all outputs at reset values immediately.
//     After release, the init sequence repeats in full.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the 4-bit HD44780-style LCD command scheduler.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_SETUP,
    S_EN_HI,
    S_EN_LO,
    S_GAP,
    S_EXEC,
    S_IDLE
  } state_t;

  // Default timings in 100 MHz clock cycles.
  localparam int unsigned DEF_T_PWRUP = 1500000;
  localparam int unsigned DEF_T_INIT1 = 410000;
  localparam int unsigned DEF_T_INIT2 = 10000;
  localparam int unsigned DEF_T_SETUP = 4;
  localparam int unsigned DEF_T_EN    = 50;
  localparam int unsigned DEF_T_GAP   = 100;
  localparam int unsigned DEF_T_CMD   = 4000;
  localparam int unsigned DEF_T_CLEAR = 164000;

  localparam logic [7:0] CMD_FUNC_4BIT = 8'h28;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;

  // Wait selectors; W_EXEC means "derive from the byte being executed".
  localparam logic [1:0] W_INIT1 = 2'd0;
  localparam logic [1:0] W_INIT2 = 2'd1;
  localparam logic [1:0] W_CMD   = 2'd2;
  localparam logic [1:0] W_EXEC  = 2'd3;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  function automatic logic is_clear(input logic rs_b, input logic [7:0] b);
    return !rs_b && (b >= 8'h01) && (b <= 8'h03);
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Power-on init sequence: four raw nibbles followed by four configuration bytes.
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [2:0] step,
  output logic       is_nibble,
  output logic       rs,
  output logic [7:0] value,
  output logic [1:0] wait_sel
);

  always_comb begin
    is_nibble = 1'b1;
    rs        = 1'b0;
    value     = 8'h03;
    wait_sel  = W_CMD;
    case (step)
      3'd0: wait_sel = W_INIT1;
      3'd1: wait_sel = W_INIT2;
      3'd2: wait_sel = W_CMD;
      3'd3: value = 8'h02;
      3'd4: begin is_nibble = 1'b0; value = CMD_FUNC_4BIT; wait_sel = W_EXEC; end
      3'd5: begin is_nibble = 1'b0; value = CMD_DISP_ON;   wait_sel = W_EXEC; end
      3'd6: begin is_nibble = 1'b0; value = CMD_CLEAR;     wait_sel = W_EXEC; end
      default: begin is_nibble = 1'b0; value = CMD_ENTRY; wait_sel = W_EXEC; end
    endcase
  end

endmodule

// File: rtl/lcd_cmd_scheduler.sv
// Owns the 4-bit LCD bus: runs power-on init, then serves client A (priority) and client B.
module lcd_cmd_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP = DEF_T_PWRUP,
  parameter int unsigned T_INIT1 = DEF_T_INIT1,
  parameter int unsigned T_INIT2 = DEF_T_INIT2,
  parameter int unsigned T_SETUP = DEF_T_SETUP,
  parameter int unsigned T_EN    = DEF_T_EN,
  parameter int unsigned T_GAP   = DEF_T_GAP,
  parameter int unsigned T_CMD   = DEF_T_CMD,
  parameter int unsigned T_CLEAR = DEF_T_CLEAR
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       a_valid,
  input  logic       a_rs,
  input  logic [7:0] a_byte,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic       b_rs,
  input  logic [7:0] b_byte,
  output logic       b_ready,
  output logic [3:0] data,
  output logic       rs,
  output logic       rw,
  output logic       en,
  output logic       init_done,
  output logic       busy
);

  state_t      state;
  logic [31:0] cnt;
  logic [2:0]  step;
  logic        cur_nib, cur_rs, cur_last, lo_phase;
  logic [7:0]  cur_byte;
  logic [1:0]  cur_wait;
  logic        rom_nib, rom_rs;
  logic [7:0]  rom_val;
  logic [1:0]  rom_wait;
  logic        do_launch, accept, sel_rs;
  logic [7:0]  sel_byte;

  lcd_init_rom u_rom (
    .step      (step),
    .is_nibble (rom_nib),
    .rs        (rom_rs),
    .value     (rom_val),
    .wait_sel  (rom_wait)
  );

  function automatic logic [31:0] wait_len(input logic [1:0] sel, input logic rs_b,
                                           input logic [7:0] b);
    case (sel)
      W_INIT1: return 32'(T_INIT1);
      W_INIT2: return 32'(T_INIT2);
      W_CMD:   return 32'(T_CMD);
      default: return is_clear(rs_b, b) ? 32'(T_CLEAR) : 32'(T_CMD);
    endcase
  endfunction

  assign rw      = 1'b0;
  assign busy    = (state != S_IDLE);
  assign a_ready = (state == S_IDLE) && init_done;
  assign b_ready = (state == S_IDLE) && init_done && !a_valid;
  assign accept  = (a_valid && a_ready) || (b_valid && b_ready);
  assign sel_rs   = a_valid ? a_rs : b_rs;
  assign sel_byte = a_valid ? a_byte : b_byte;

  // Start the next init step after power-up, after a raw nibble, or after an init byte.
  assign do_launch = (cnt == 32'd0) &&
                     ((state == S_PWRUP) || (state == S_EN_LO) ||
                      ((state == S_EXEC) && !init_done && !cur_last));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_PWRUP;
      cnt       <= 32'(T_PWRUP - 1);
      step      <= 3'd0;
      cur_nib   <= 1'b0;
      cur_rs    <= 1'b0;
      cur_last  <= 1'b0;
      lo_phase  <= 1'b0;
      cur_byte  <= 8'h00;
      cur_wait  <= W_CMD;
      data      <= 4'h0;
      rs        <= 1'b0;
      en        <= 1'b0;
      init_done <= 1'b0;
    end else if (do_launch) begin
      state    <= S_SETUP;
      cnt      <= 32'(T_SETUP - 1);
      step     <= step + 3'd1;
      cur_nib  <= rom_nib;
      cur_rs   <= rom_rs;
      cur_byte <= rom_val;
      cur_wait <= rom_wait;
      cur_last <= (step == 3'd7);
      lo_phase <= 1'b0;
      rs       <= rom_rs;
      data     <= rom_nib ? rom_val[3:0] : rom_val[7:4];
    end else if (accept) begin
      state    <= S_SETUP;
      cnt      <= 32'(T_SETUP - 1);
      cur_nib  <= 1'b0;
      cur_rs   <= sel_rs;
      cur_byte <= sel_byte;
      cur_wait <= W_EXEC;
      cur_last <= 1'b0;
      lo_phase <= 1'b0;
      rs       <= sel_rs;
      data     <= sel_byte[7:4];
    end else begin
      case (state)
        S_SETUP:
          if (cnt == 32'd0) begin
            state <= S_EN_HI;
            en    <= 1'b1;
            cnt   <= 32'(T_EN - 1);
          end else cnt <= cnt - 32'd1;
        S_EN_HI:
          if (cnt == 32'd0) begin
            en <= 1'b0;
            if (cur_nib) begin
              state <= S_EN_LO;
              cnt   <= wait_len(cur_wait, cur_rs, cur_byte) - 32'd1;
            end else if (!lo_phase) begin
              state <= S_GAP;
              cnt   <= 32'(T_GAP - 1);
            end else begin
              state <= S_EXEC;
              cnt   <= wait_len(cur_wait, cur_rs, cur_byte) - 32'd1;
            end
          end else cnt <= cnt - 32'd1;
        // data/rs change only here, at the start of the lo-nibble setup
        S_GAP:
          if (cnt == 32'd0) begin
            state    <= S_SETUP;
            lo_phase <= 1'b1;
            data     <= cur_byte[3:0];
            cnt      <= 32'(T_SETUP - 1);
          end else cnt <= cnt - 32'd1;
        S_EXEC:
          if (cnt == 32'd0) begin
            state     <= S_IDLE;
            init_done <= 1'b1;
          end else cnt <= cnt - 32'd1;
        S_PWRUP, S_EN_LO: cnt <= cnt - 32'd1;
        S_IDLE: ;
        default: state <= S_PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// Directed bench: expected EN-pulse nibbles are queued as stimulus is driven and popped on each EN rise.
module tb_lcd_cmd_scheduler;

  localparam int T_PWRUP = 200;
  localparam int T_INIT1 = 50;
  localparam int T_INIT2 = 20;
  localparam int T_SETUP = 4;
  localparam int T_EN    = 50;
  localparam int T_GAP   = 100;
  localparam int T_CMD   = 10;
  localparam int T_CLEAR = 30;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       a_valid = 1'b0, a_rs = 1'b0, b_valid = 1'b0, b_rs = 1'b0;
  logic [7:0] a_byte = 8'h00, b_byte = 8'h00;
  logic       a_ready, b_ready, rs, rw, en, init_done, busy;
  logic [3:0] data;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_fall = 0;
  logic [4:0] q[$];

  lcd_cmd_scheduler #(
    .T_PWRUP(T_PWRUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_SETUP(T_SETUP),
    .T_EN(T_EN), .T_GAP(T_GAP), .T_CMD(T_CMD), .T_CLEAR(T_CLEAR)
  ) dut (
    .clk(clk), .nrst(nrst),
    .a_valid(a_valid), .a_rs(a_rs), .a_byte(a_byte), .a_ready(a_ready),
    .b_valid(b_valid), .b_rs(b_rs), .b_byte(b_byte), .b_ready(b_ready),
    .data(data), .rs(rs), .rw(rw), .en(en), .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic rs_b, input logic [7:0] b);
    q.push_back({rs_b, b[7:4]});
    q.push_back({rs_b, b[3:0]});
  endtask

  task automatic push_init();
    q.push_back(5'h03); q.push_back(5'h03); q.push_back(5'h03); q.push_back(5'h02);
    push_byte(1'b0, 8'h28); push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h01); push_byte(1'b0, 8'h06);
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < max);
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_init(input int max, output logic early);
    int n = 0;
    early = 1'b0;
    do begin
      @(negedge clk); n++;
      if (!init_done && b_ready) early = 1'b1;
    end while (!init_done && n < max);
  endtask

  // Bus monitor: every EN pulse must match the queue, last T_EN cycles, and hold data/rs.
  logic       prev_en = 1'b0;
  int         width = 0;
  logic [4:0] rise_v, exp_v;
  always @(negedge clk) begin
    if (!nrst) prev_en = 1'b0;
    else begin
      if (en && !prev_en) begin
        rise_v = {rs, data};
        width  = 1;
        chk("pulse_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          exp_v = q.pop_front();
          chk("nibble", 32'(rise_v), 32'(exp_v));
        end
        chk("rw_zero", 32'(rw), 32'd0);
      end else if (en) width++;
      if (!en && prev_en) begin
        chk("en_width", 32'(width), 32'(T_EN));
        chk("hold_after_fall", 32'({rs, data}), 32'(rise_v));
        last_fall = cyc;
      end
      prev_en = en;
    end
  end

  logic [7:0] t4_byte[5] = '{8'h01, 8'h03, 8'h04, 8'h01, 8'h00};
  logic       t4_rs[5]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  int         t4_wait[5] = '{T_CLEAR, T_CLEAR, T_CMD, T_CMD, T_CMD};
  logic       early;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({data, rs, rw, en, a_ready, b_ready, init_done, busy}), 32'h001);

    // Power-on init
    push_init();
    nrst = 1'b1;
    wait_init(5000, early);
    chk("init_done", 32'(init_done), 32'd1);
    chk("init_last_exec", 32'(cyc - last_fall), 32'(T_CMD));
    chk("init_pulses_left", 32'(q.size()), 32'd0);
    chk("idle_after_init", 32'(busy), 32'd0);

    // Character write from B
    b_valid = 1'b1; b_rs = 1'b1; b_byte = 8'h41;
    push_byte(1'b1, 8'h41);
    #1 chk("b_ready_idle", 32'(b_ready), 32'd1);
    @(negedge clk);
    b_valid = 1'b0;
    chk("hi_nibble_next_cycle", 32'({rs, data}), 32'h14);
    chk("en_low_at_setup", 32'(en), 32'd0);
    repeat (T_SETUP - 1) @(negedge clk);
    chk("en_before_setup_end", 32'(en), 32'd0);
    @(negedge clk);
    chk("en_after_setup", 32'(en), 32'd1);
    wait_idle("b41_done", 1000);
    chk("b41_pulses_left", 32'(q.size()), 32'd0);

    // A and B together: A first, B at the next IDLE
    a_valid = 1'b1; a_rs = 1'b1; a_byte = 8'h5A;
    b_valid = 1'b1; b_rs = 1'b1; b_byte = 8'h33;
    push_byte(1'b1, 8'h5A); push_byte(1'b1, 8'h33);
    #1 chk("arb_a_ready", 32'(a_ready), 32'd1);
    chk("arb_b_ready", 32'(b_ready), 32'd0);
    @(negedge clk);
    a_valid = 1'b0;
    chk("arb_a_first", 32'({rs, data}), 32'h15);
    wait_idle("a5a_done", 1000);
    chk("b_ready_next_idle", 32'(b_ready), 32'd1);
    @(negedge clk);
    b_valid = 1'b0;
    chk("b_accepted", 32'(busy), 32'd1);
    wait_idle("b33_done", 1000);
    chk("arb_pulses_left", 32'(q.size()), 32'd0);

    // Execution wait selection around the clear/home range
    for (int i = 0; i < 5; i++) begin
      a_valid = 1'b1; a_rs = t4_rs[i]; a_byte = t4_byte[i];
      push_byte(t4_rs[i], t4_byte[i]);
      @(negedge clk);
      a_valid = 1'b0;
      wait_idle("exec_done", 1000);
      chk("exec_wait", 32'(cyc - last_fall), 32'(t4_wait[i]));
    end
    chk("exec_pulses_left", 32'(q.size()), 32'd0);

    // Reset while EN is high, then B held through the repeated init
    b_valid = 1'b1; b_rs = 1'b1; b_byte = 8'h7E;
    q.push_back(5'h17);
    @(negedge clk);
    b_valid = 1'b0;
    for (int n = 0; n < 100 && !en; n++) @(negedge clk);
    chk("en_rose", 32'(en), 32'd1);
    repeat (10) @(negedge clk);
    #2 nrst = 1'b0;
    #1 chk("midbyte_reset_outputs",
           32'({data, rs, rw, en, a_ready, b_ready, init_done, busy}), 32'h001);
    chk("midbyte_pulses_left", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
    push_init();
    push_byte(1'b1, 8'h21);
    b_valid = 1'b1; b_rs = 1'b1; b_byte = 8'h21;
    nrst = 1'b1;
    wait_init(5000, early);
    chk("b_ready_during_init", 32'(early), 32'd0);
    chk("reinit_done", 32'(init_done), 32'd1);
    chk("b_ready_first_idle", 32'(b_ready), 32'd1);
    chk("reinit_pulses_left", 32'(q.size()), 32'd2);
    @(negedge clk);
    b_valid = 1'b0;
    chk("b_accept_first_idle", 32'(busy), 32'd1);
    wait_idle("b21_done", 1000);
    chk("final_pulses_left", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
